// File: rtl/shift_reg_seq.sv
// rtl/shift_reg_seq.sv - WIDTH-bit shift register with load, single-step and shift-by-N sequences
module shift_reg_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] dph,
  input  logic             sft,
  input  logic             start,
  input  logic [SHW-1:0]   amt,
  input  logic [1:0]       mode,
  input  logic             sin,
  output logic [WIDTH-1:0] qph,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] qph_q, qph_d;
  logic             sout_q, sout_d;
  logic             done_q, done_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [1:0]       mode_q, mode_d;

  // One shift step: returns {bit shifted out, new register value}.
  function automatic logic [WIDTH:0] shift_step(input logic [WIDTH-1:0] q,
                                                input logic [1:0]       m,
                                                input logic             s);
    logic [WIDTH:0] r;
    case (m)
      2'b00:   r = {q[0],       s,        q[WIDTH-1:1]};
      2'b01:   r = {q[WIDTH-1], q[WIDTH-2:0], s};
      2'b10:   r = {q[0],       q[WIDTH-1], q[WIDTH-1:1]};
      default: r = {q[0],       q[0],     q[WIDTH-1:1]};
    endcase
    return r;
  endfunction

  // Next-state: a running sequence owns the register; otherwise load > start > sft.
  always_comb begin
    state_d = state_q;
    qph_d   = qph_q;
    sout_d  = sout_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          qph_d = dph;
        end else if (start) begin
          if (amt != '0) begin
            mode_d  = mode;
            cnt_d   = amt;
            state_d = ST_RUN;
          end else begin
            done_d = 1'b1;
          end
        end else if (sft) begin
          {sout_d, qph_d} = shift_step(qph_q, mode, sin);
        end
      end
      default: begin
        {sout_d, qph_d} = shift_step(qph_q, mode_q, sin);
        cnt_d = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
    endcase
  end

  // State registers; clr aborts any sequence without a done pulse.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= ST_IDLE;
      qph_q   <= '0;
      sout_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      mode_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      qph_q   <= qph_d;
      sout_q  <= sout_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  assign qph  = qph_q;
  assign sout = sout_q;
  assign busy = (state_q == ST_RUN);
  assign done = done_q;

endmodule

// File: tb/tb_shift_reg_seq.sv
// tb/tb_shift_reg_seq.sv - scoreboard bench for shift_reg_seq
module tb_shift_reg_seq;
  localparam int W   = 8;
  localparam int SHW = 4;

  logic           clk = 1'b0;
  logic           clr, load, sft, start, sin;
  logic [W-1:0]   dph;
  logic [SHW-1:0] amt;
  logic [1:0]     mode;
  logic [W-1:0]   qph;
  logic           sout, busy, done;

  shift_reg_seq #(.WIDTH(W), .SHW(SHW)) dut (
    .clk(clk), .clr(clr), .load(load), .dph(dph), .sft(sft), .start(start),
    .amt(amt), .mode(mode), .sin(sin), .qph(qph), .sout(sout), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int exp_done = 0;
  int seen_done = 0;
  logic [W:0] exp_q[$];
  logic [W-1:0] q_m;
  logic s_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: N shifts as a bit stream. Non-rotating modes see the register bits
  // in shift-out order followed by the fill bits; the window N..N+W-1 is the result.
  function automatic logic [W:0] model(input logic [W-1:0] q, input int n,
                                       input logic [1:0] m, input bit s[64]);
    bit L[64];
    logic [W-1:0] qn;
    logic [2*W-1:0] dbl;
    int k;
    if (m == 2'b11) begin
      k = n % W;
      dbl = {q, q} >> k;
      return {q[(n - 1) % W], dbl[W-1:0]};
    end
    for (int i = 0; i < W; i++) L[i] = (m == 2'b01) ? q[W-1-i] : q[i];
    for (int j = 0; j < n; j++) L[W+j] = (m == 2'b10) ? q[W-1] : s[j];
    for (int i = 0; i < W; i++) begin
      if (m == 2'b01) qn[W-1-i] = L[n+i];
      else            qn[i]     = L[n+i];
    end
    return {L[n-1], qn};
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      seen_done++;
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_done: got done=1 expected no pending sequence at %0t", $time);
      end else begin
        logic [W:0] e;
        e = exp_q.pop_front();
        chk("done_qph", 32'(qph), 32'(e[W-1:0]));
        chk("done_sout", 32'(sout), 32'(e[W]));
        chk("done_busy", 32'(busy), 32'd0);
      end
    end
  end

  task automatic do_load(input logic [W-1:0] d);
    load = 1'b1; dph = d;
    step();
    load = 1'b0;
    q_m = d;
    chk("load_qph", 32'(qph), 32'(q_m));
    chk("load_sout", 32'(sout), 32'(s_m));
  endtask

  task automatic do_sft(input logic [1:0] m, input logic s);
    bit sv[64];
    logic [W:0] r;
    sft = 1'b1; mode = m; sin = s;
    step();
    sft = 1'b0;
    sv[0] = s;
    r = model(q_m, 1, m, sv);
    chk("sft_qph", 32'(qph), 32'(r[W-1:0]));
    chk("sft_sout", 32'(sout), 32'(r[W]));
    q_m = r[W-1:0]; s_m = r[W];
  endtask

  // sinmode < 0: random sin per edge; otherwise constant. abort_k > 0: clr at edge E<abort_k>.
  task automatic run_seq(input int n, input logic [1:0] m, input int sinmode,
                         input bit noise, input int abort_k);
    bit sv[64];
    logic [W:0] r;
    logic [W-1:0] q0;
    q0 = q_m;
    for (int j = 0; j < 64; j++) sv[j] = (sinmode < 0) ? bit'($urandom % 2) : bit'(sinmode);
    if (n == 0) begin
      exp_q.push_back({s_m, q_m}); exp_done++;
    end else if (abort_k == 0) begin
      exp_q.push_back(model(q0, n, m, sv)); exp_done++;
    end
    start = 1'b1; amt = SHW'(n); mode = m; sin = 1'($urandom);
    step();
    start = 1'b0;
    chk("start_busy", 32'(busy), 32'(n != 0));
    for (int k = 1; k <= n; k++) begin
      sin = sv[k-1];
      mode = 2'($urandom);
      if (noise) begin
        load = 1'b1; dph = '1; sft = 1'b1; start = 1'b1; amt = SHW'($urandom);
      end
      if (k == abort_k) clr = 1'b1;
      step();
      load = 1'b0; sft = 1'b0; start = 1'b0; clr = 1'b0;
      if (k == abort_k) begin
        chk("abort_qph", 32'(qph), 32'd0);
        chk("abort_sout", 32'(sout), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        q_m = '0; s_m = 1'b0;
        return;
      end
      r = model(q0, k, m, sv);
      chk("seq_qph", 32'(qph), 32'(r[W-1:0]));
      chk("seq_sout", 32'(sout), 32'(r[W]));
      chk("seq_busy", 32'(busy), 32'(k < n));
      q_m = r[W-1:0]; s_m = r[W];
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    clr = 1'b1; load = 1'b0; sft = 1'b0; start = 1'b0; sin = 1'b0;
    dph = '0; amt = '0; mode = 2'b00;
    step(); step();
    clr = 1'b0;
    chk("rst_qph", 32'(qph), 32'd0);
    chk("rst_sout", 32'(sout), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    q_m = '0; s_m = 1'b0;

    do_load(8'hB4);
    do_sft(2'b00, 1'b1);
    chk("plan_sft", 32'(qph), 32'hDA);

    do_load(8'h96);
    run_seq(3, 2'b10, -1, 1'b0, 0);
    chk("plan_asr", {qph, sout}, {8'hF2, 1'b1});
    step();
    chk("plan_done_low", 32'(done), 32'd0);

    do_load(8'h81);
    run_seq(2, 2'b01, 0, 1'b0, 0);
    chk("plan_lsl", 32'(qph), 32'h04);

    do_load(8'h5A);
    run_seq(8, 2'b11, -1, 1'b0, 0);
    chk("plan_rot", 32'(qph), 32'h5A);
    step();
    run_seq(0, 2'b00, -1, 1'b0, 0);
    chk("plan_amt0", 32'(qph), 32'h5A);
    step();

    do_load(8'h3C);
    run_seq(5, 2'b00, -1, 1'b1, 0);
    do_load(8'h3C);
    run_seq(5, 2'b00, -1, 1'b1, 2);
    step(); step(); step();

    do_load(8'hC3);
    run_seq(4, 2'b10, -1, 1'b0, 0);
    run_seq(6, 2'b00, -1, 1'b0, 0);
    run_seq(15, 2'b11, -1, 1'b1, 0);
    run_seq(12, 2'b01, -1, 1'b0, 0);

    for (int it = 0; it < 60; it++) begin
      case ($urandom % 4)
        0: do_load(W'($urandom));
        1: do_sft(2'($urandom), 1'($urandom));
        default: run_seq(int'($urandom % 16), 2'($urandom), -1, bit'($urandom % 2), 0);
      endcase
      if ($urandom % 3 == 0) step();
    end

    step(); step(); step();
    chk("pending_empty", 32'(exp_q.size()), 32'd0);
    chk("done_count", 32'(seen_done), 32'(exp_done));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
